ramif_rd_stream: RTL
====================

// Module: ramif_rd_stream
// PURPOSE
// - Drain engine for the read side of a ramif FIFO, i.e. the side with dir=0.
// - Issues rinc pulses against the FIFO's empty flag and collects the RAM read data RD_LAT cycles later.
// - Presents the collected words as a valid/ready stream through a small prefetch buffer.
// - Single clock domain: the clock of the reading side.
// PARAMETERS
// - DSIZE     8  word width, including the parity bit when RAMIF_RD_PARITY_EN is defined
// - RD_LAT    1  RAM read latency in cycles, from o_fifo_rinc to i_fifo_rdata valid; legal range 0..3
// - BUF_DEPTH 3  prefetch entries; must be >= RD_LAT+1; full rate needs >= RD_LAT+2
// PORTS
// - clk           in   1              clock
// - rst           in   1              synchronous reset, active high
// - i_fifo_empty  in   1              FIFO empty flag; registered, already accounts for the last rinc
// - o_fifo_rinc   out  1              FIFO read increment; also the RAM read enable
// - i_fifo_rdata  in   DSIZE          RAM read data
// - i_flush       in   1              discard buffered and in-flight words
// - o_valid       out  1              stream word available
// - o_data        out  DSIZE          stream word
// - i_ready       in   1              consumer accepts the word
// - o_level       out  clog2(BUF_DEPTH+1)  buffered words plus in-flight words
// - o_perr        out  1              parity error pulse (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all of the following are 0 in the cycle after rst is high: count, in-flight pipe, pointers, o_valid, o_level, o_perr.
// - Reset: o_fifo_rinc is 0 while rst=1.
// - Issue rule: o_fifo_rinc = !rst & !i_flush & !i_fifo_empty & (o_level < BUF_DEPTH).
// - o_level is the registered count plus the in-flight count; a pop in the same cycle does not free a slot until the next cycle.
// - In-flight tracking: an RD_LAT-deep shift register of valid bits.
// - A rinc at cycle t: the word on i_fifo_rdata is written to the tail at edge t+RD_LAT.
// - RD_LAT=0: the word is captured at the same edge as the rinc.
// - Buffer: a circular array; head and tail pointers wrap from BUF_DEPTH-1 to 0, so BUF_DEPTH need not be a power of two.
// - o_valid = (count != 0). o_data = head entry when o_valid=1, otherwise forced to 0.
// - Pop occurs on o_valid & i_ready.
// - A push and a pop in the same cycle leave count unchanged; both pointers advance.
// - The credit rule guarantees a push never finds the buffer full. A push into a full buffer is an assertion failure.
// - Throughput: 1 word/cycle sustained when BUF_DEPTH >= RD_LAT+2 and the FIFO stays non-empty.
// - First-word latency from i_fifo_empty falling: RD_LAT+1 cycles to o_valid.
// - i_flush (level sensitive, every cycle it is high):
//   - no rinc is issued;
//   - the in-flight pipe is cleared, and data returning for cleared slots is dropped;
//   - count and pointers go to 0, so o_valid=0 next cycle.
//   - Flushed words are lost; the FIFO read pointer has already advanced.
// - Flush and pop in the same cycle: the flush wins; the pop is still seen by the consumer in that cycle.
// - rst high mid-burst behaves like a flush plus a clear of o_perr. The FIFO's own pointers are reset separately by its owner.
// - o_level width arithmetic is unsigned; the maximum value is BUF_DEPTH and it never wraps.
// CONFIGURATION
// - RAMIF_RD_PARITY_EN defined:
//   - bit DSIZE-1 of each word is even parity over [DSIZE-2:0];
//   - the check is made at capture;
//   - o_perr pulses high for 1 cycle in the cycle after a bad word is captured;
//   - the bad word is still buffered and delivered unchanged;
//   - a flushed or dropped word is never checked.
// - RAMIF_RD_PARITY_EN undefined: no check logic; o_perr is tied to 0.
// TESTING
// - Reset, FIFO empty: o_valid=0, o_fifo_rinc=0, o_level=0 for 10 cycles.
// - RD_LAT=1, BUF_DEPTH=3, i_ready=1, FIFO holds 0x11..0x18:
//   first o_valid 2 cycles after empty deasserts; 8 consecutive beats 0x11..0x18; o_level never exceeds 3.
// - i_ready=0 with 8 words available: exactly 3 rincs are issued, then o_level=3 holds.
//   On i_ready=1, 0x11,0x12,0x13 come out in order with no duplicates.
// - Flush asserted 1 cycle after a rinc, with 2 words buffered: next cycle o_valid=0 and o_level=0.
//   The in-flight word is not delivered; the next delivered word is the FIFO's next entry.
// - RD_LAT=2, BUF_DEPTH=5, random i_ready:
//   the scoreboard matches the FIFO sequence, the pointers wrap past index 4 correctly, and no push is made into a full buffer.
// - RAMIF_RD_PARITY_EN, word 0x83 (bad parity): o_perr=1 for exactly 1 cycle, and 0x83 is still delivered.

Source files
------------

// File: rtl/ramif_rd_stream.sv
// Read-side drain engine: issues rinc against the FIFO empty flag and streams words out.
// Optional parity check on captured words when RAMIF_RD_PARITY_EN is defined.
module ramif_rd_stream #(
  parameter int DSIZE     = 8,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_fifo_empty,
  output logic                           o_fifo_rinc,
  input  logic [DSIZE-1:0]               i_fifo_rdata,
  input  logic                           i_flush,
  output logic                           o_valid,
  output logic [DSIZE-1:0]               o_data,
  input  logic                           i_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0] o_level,
  output logic                           o_perr
);

  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DSIZE-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [LW-1:0]    count;
  logic [LW-1:0]    infl;
  logic [LW-1:0]    level;
  logic             push;
  logic             take;
  logic             pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit covers words still in the RAM read pipe, so a push always has room.
  assign level       = count + infl;
  assign o_level     = level;
  assign o_valid     = (count != '0);
  assign o_data      = o_valid ? mem[head] : '0;
  assign pop         = o_valid & i_ready;
  assign o_fifo_rinc = !rst & !i_flush & !i_fifo_empty
                     & (level < LW'(BUF_DEPTH));
  assign take        = push & !i_flush & !rst;

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign push = o_fifo_rinc;
      assign infl = '0;
    end else begin : g_pipe
      logic [RD_LAT-1:0] pipe;

      always_ff @(posedge clk) begin
        if (rst || i_flush) begin
          pipe <= '0;
        end else begin
          pipe[0] <= o_fifo_rinc;
          for (int i = 1; i < RD_LAT; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) begin
          infl = infl + LW'(pipe[i]);
        end
      end

      assign push = pipe[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (take) begin
      mem[tail] <= i_fifo_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (take) begin
        tail <= wrap_inc(tail);
      end
      if (pop) begin
        head <= wrap_inc(head);
      end
      case ({take, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      assert (count != LW'(BUF_DEPTH));
    end
  end

`ifdef RAMIF_RD_PARITY_EN
  // Even parity over the whole word, parity bit included, must reduce to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perr <= 1'b0;
    end else begin
      o_perr <= take & (^i_fifo_rdata);
    end
  end
`else
  assign o_perr = 1'b0;
`endif

endmodule
